// File: rtl/rom_dl_ctrl_pkg.sv
// Shared core definitions: download FSM states, ROM set defaults and ROM region bases.
package rom_dl_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_RUN
    } dl_state_t;

    localparam logic [7:0]  ROM_INDEX_DEF = 8'd0;
    localparam logic [24:0] ROM_SIZE_DEF  = 25'h58300;

    // Byte offsets of each ROM region inside the downloaded set
    localparam logic [24:0] MAIN_CPU_BASE  = 25'h00000;
    localparam logic [24:0] SOUND_CPU_BASE = 25'h40000;
    localparam logic [24:0] GFX_BASE       = 25'h48000;
    localparam logic [24:0] PROM_BASE      = 25'h58000;

endpackage

// File: rtl/dl_fifo2.sv
// Two-entry first-word-fall-through FIFO; head entry is always at mem0.
module dl_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic         full
);

    logic [1:0]   count;
    logic [W-1:0] mem0, mem1;
    logic         do_push, do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign rdata   = mem0;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= wdata;
                    else               mem1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new byte lands behind the surviving entry
                    if (count == 2'd1) begin
                        mem0 <= wdata;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Game ROM download controller: buffers HPS ioctl bytes, checks length/checksum, sequences core reset.
module rom_dl_ctrl
    import rom_dl_ctrl_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX   = ROM_INDEX_DEF,
    parameter logic [24:0] ROM_SIZE    = ROM_SIZE_DEF,
    parameter int          HOLD_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IOCTL_DOWNLOAD,
    input  logic [7:0]  IOCTL_INDEX,
    input  logic        IOCTL_WR,
    input  logic [24:0] IOCTL_ADDR,
    input  logic [7:0]  IOCTL_DATA,
    output logic        IOCTL_WAIT,
    output logic [24:0] DL_ADDR,
    output logic [7:0]  DL_DATA,
    output logic        DL_VALID,
    input  logic        DL_READY,
    output logic        CORE_RESET,
    output logic        ROM_OK,
    output logic        ROM_SHORT,
    output logic        OVERRUN,
    output logic [15:0] CHECKSUM
);

    localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    dl_state_t     state;
    logic          wr_q, dl_q, start_pend;
    logic [24:0]   byte_cnt;
    logic [HW-1:0] hold_cnt;
    logic          fifo_full, start, accept, pop, push, drop, go_load;

    // dl_q resets high so a session still open across RESET is not treated as new
    assign start  = IOCTL_DOWNLOAD && !dl_q && (IOCTL_INDEX == ROM_INDEX);
    assign accept = (state == ST_LOAD) && IOCTL_WR && !wr_q;
    assign pop    = DL_VALID && DL_READY;
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;
    assign IOCTL_WAIT = fifo_full;

    always_comb begin
        go_load = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: go_load = start;
            ST_HOLD:         go_load = start || start_pend;
            default:         go_load = 1'b0;
        endcase
    end

    dl_fifo2 #(.W(33)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .wdata ({IOCTL_ADDR, IOCTL_DATA}),
        .pop   (pop),
        .rdata ({DL_ADDR, DL_DATA}),
        .valid (DL_VALID),
        .full  (fifo_full)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            dl_q       <= 1'b1;
            start_pend <= 1'b0;
            byte_cnt   <= '0;
            hold_cnt   <= '0;
            CHECKSUM   <= '0;
            ROM_OK     <= 1'b0;
            ROM_SHORT  <= 1'b0;
            OVERRUN    <= 1'b0;
            CORE_RESET <= 1'b1;
        end else begin
            wr_q <= IOCTL_WR;
            dl_q <= IOCTL_DOWNLOAD;
            if (go_load) begin
                state      <= ST_LOAD;
                start_pend <= 1'b0;
                byte_cnt   <= '0;
                CHECKSUM   <= '0;
                ROM_OK     <= 1'b0;
                ROM_SHORT  <= 1'b0;
                OVERRUN    <= 1'b0;
                CORE_RESET <= 1'b1;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (push) begin
                            CHECKSUM <= CHECKSUM + {8'd0, IOCTL_DATA};
                            if (byte_cnt != '1) byte_cnt <= byte_cnt + 25'd1;
                        end
                        if (drop) OVERRUN <= 1'b1;
                        if (!IOCTL_DOWNLOAD) state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (start) start_pend <= 1'b1;
                        if (!DL_VALID) begin
                            state     <= ST_HOLD;
                            hold_cnt  <= HOLD_LAST;
                            ROM_SHORT <= (byte_cnt < ROM_SIZE);
                            ROM_OK    <= !(byte_cnt < ROM_SIZE) && !OVERRUN;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == '0) begin
                            state      <= ST_RUN;
                            CORE_RESET <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    ST_IDLE, ST_RUN: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench: u_small (ROM_SIZE=16) for main flows, u_full (default size) for the short-ROM case.
module tb_rom_dl_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        IOCTL_DOWNLOAD = 1'b0;
    logic [7:0]  IOCTL_INDEX = 8'd0;
    logic        IOCTL_WR = 1'b0;
    logic [24:0] IOCTL_ADDR = '0;
    logic [7:0]  IOCTL_DATA = '0;
    logic        DL_READY = 1'b1;

    logic        s_wait, s_valid, s_core, s_ok, s_short, s_ovr;
    logic [24:0] s_addr;
    logic [7:0]  s_data;
    logic [15:0] s_sum;
    logic        f_wait, f_valid, f_core, f_ok, f_short, f_ovr;
    logic [24:0] f_addr;
    logic [7:0]  f_data;
    logic [15:0] f_sum;

    int n_chk = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    rom_dl_ctrl #(.ROM_INDEX(8'd0), .ROM_SIZE(25'd16), .HOLD_CYCLES(256)) u_small (
        .CLK(CLK), .RESET(RESET), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
        .IOCTL_WR(IOCTL_WR), .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DATA(IOCTL_DATA), .IOCTL_WAIT(s_wait),
        .DL_ADDR(s_addr), .DL_DATA(s_data), .DL_VALID(s_valid), .DL_READY(DL_READY),
        .CORE_RESET(s_core), .ROM_OK(s_ok), .ROM_SHORT(s_short), .OVERRUN(s_ovr), .CHECKSUM(s_sum)
    );

    rom_dl_ctrl u_full (
        .CLK(CLK), .RESET(RESET), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
        .IOCTL_WR(IOCTL_WR), .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DATA(IOCTL_DATA), .IOCTL_WAIT(f_wait),
        .DL_ADDR(f_addr), .DL_DATA(f_data), .DL_VALID(f_valid), .DL_READY(DL_READY),
        .CORE_RESET(f_core), .ROM_OK(f_ok), .ROM_SHORT(f_short), .OVERRUN(f_ovr), .CHECKSUM(f_sum)
    );

    // one strobe: high for one cycle, low for one cycle
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        IOCTL_ADDR = a; IOCTL_DATA = d; IOCTL_WR = 1'b1;
        @(negedge CLK);
        IOCTL_WR = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        #2 RESET = 1'b1;
        #1;
        n_chk++; if ({s_valid, s_wait} !== 2'b00) $display("FAIL reset_valid_wait got %b exp 00", {s_valid, s_wait}); else n_pass++;
        n_chk++; if ({s_core, s_ok, s_short, s_ovr} !== 4'b1000) $display("FAIL reset_flags got %b exp 1000", {s_core, s_ok, s_short, s_ovr}); else n_pass++;
        n_chk++; if ({s_sum, s_addr, s_data} !== 49'd0) $display("FAIL reset_data got %h exp 0", {s_sum, s_addr, s_data}); else n_pass++;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_basic;
        IOCTL_INDEX = 8'd0; IOCTL_DOWNLOAD = 1'b1; DL_READY = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 16; i++) begin
            IOCTL_ADDR = 25'(i); IOCTL_DATA = 8'(i + 1); IOCTL_WR = 1'b1;
            @(negedge CLK);
            n_chk++; if (s_valid !== 1'b1) $display("FAIL basic_valid_rise[%0d] got %b exp 1", i, s_valid); else n_pass++;
            n_chk++; if (s_addr !== 25'(i) || s_data !== 8'(i + 1)) $display("FAIL basic_entry[%0d] got %h/%h exp %h/%h", i, s_addr, s_data, i, i + 1); else n_pass++;
            IOCTL_WR = 1'b0;
            @(negedge CLK);
            n_chk++; if (s_valid !== 1'b0) $display("FAIL basic_valid_pop[%0d] got %b exp 0", i, s_valid); else n_pass++;
        end
        IOCTL_DOWNLOAD = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++; if (s_sum !== 16'h0088) $display("FAIL basic_checksum got %h exp 0088", s_sum); else n_pass++;
        n_chk++; if ({s_ok, s_short, s_ovr} !== 3'b100) $display("FAIL basic_flags got %b exp 100", {s_ok, s_short, s_ovr}); else n_pass++;
        repeat (255) @(negedge CLK);
        n_chk++; if (s_core !== 1'b1) $display("FAIL basic_core_hold got %b exp 1", s_core); else n_pass++;
        @(negedge CLK);
        n_chk++; if (s_core !== 1'b0) $display("FAIL basic_core_release got %b exp 0", s_core); else n_pass++;
    endtask

    task automatic test_overrun;
        DL_READY = 1'b0; IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        n_chk++; if ({s_core, s_sum} !== 17'h10000) $display("FAIL ovr_load_clear got %h exp 10000", {s_core, s_sum}); else n_pass++;
        wr_byte(25'h100, 8'h11);
        n_chk++; if ({s_valid, s_wait} !== 2'b10) $display("FAIL ovr_one_entry got %b exp 10", {s_valid, s_wait}); else n_pass++;
        wr_byte(25'h101, 8'h22);
        n_chk++; if (s_wait !== 1'b1) $display("FAIL ovr_wait_full got %b exp 1", s_wait); else n_pass++;
        wr_byte(25'h102, 8'h33);
        n_chk++; if (s_ovr !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", s_ovr); else n_pass++;
        n_chk++; if (s_addr !== 25'h100 || s_data !== 8'h11) $display("FAIL ovr_head_stable got %h/%h exp 100/11", s_addr, s_data); else n_pass++;
        DL_READY = 1'b1;
        @(negedge CLK);
        n_chk++; if (s_addr !== 25'h101 || s_data !== 8'h22) $display("FAIL ovr_second got %h/%h exp 101/22", s_addr, s_data); else n_pass++;
        repeat (2) @(negedge CLK);
        n_chk++; if (s_valid !== 1'b0) $display("FAIL ovr_drained got %b exp 0", s_valid); else n_pass++;
        IOCTL_DOWNLOAD = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++; if (s_sum !== 16'h0033) $display("FAIL ovr_checksum got %h exp 0033", s_sum); else n_pass++;
        n_chk++; if ({s_ok, s_ovr} !== 2'b01) $display("FAIL ovr_rom_ok got %b exp 01", {s_ok, s_ovr}); else n_pass++;
    endtask

    task automatic test_held_wr;
        // starts in HOLD: a matching session restarts LOAD and clears flags
        DL_READY = 1'b0; IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        n_chk++; if ({s_ovr, s_core} !== 2'b01) $display("FAIL held_restart got %b exp 01", {s_ovr, s_core}); else n_pass++;
        IOCTL_ADDR = 25'h5; IOCTL_DATA = 8'h5A; IOCTL_WR = 1'b1;
        repeat (5) @(negedge CLK);
        IOCTL_WR = 1'b0;
        @(negedge CLK);
        n_chk++; if ({s_valid, s_wait} !== 2'b10) $display("FAIL held_one_entry got %b exp 10", {s_valid, s_wait}); else n_pass++;
        n_chk++; if (s_sum !== 16'h005A) $display("FAIL held_checksum got %h exp 005a", s_sum); else n_pass++;
        DL_READY = 1'b1;
        @(negedge CLK);
        n_chk++; if (s_valid !== 1'b0) $display("FAIL held_single_pop got %b exp 0", s_valid); else n_pass++;
        IOCTL_DOWNLOAD = 1'b0;
        repeat (262) @(negedge CLK);
        n_chk++; if ({s_core, s_ok, s_short} !== 3'b001) $display("FAIL held_run got %b exp 001", {s_core, s_ok, s_short}); else n_pass++;
    endtask

    task automatic test_other_index;
        logic seen;
        seen = 1'b0;
        IOCTL_INDEX = 8'd1; IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 100; i++) begin
            wr_byte(25'(i), 8'(i + 7));
            if (s_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL idx1_no_valid got %b exp 0", seen); else n_pass++;
        n_chk++; if (s_sum !== 16'h005A) $display("FAIL idx1_checksum got %h exp 005a", s_sum); else n_pass++;
        n_chk++; if ({s_core, s_ok, s_short, s_ovr} !== 4'b0010) $display("FAIL idx1_flags got %b exp 0010", {s_core, s_ok, s_short, s_ovr}); else n_pass++;
        IOCTL_DOWNLOAD = 1'b0; IOCTL_INDEX = 8'd0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_short;
        DL_READY = 1'b1; IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 'h1000; i++) wr_byte(25'(i), 8'(i));
        IOCTL_DOWNLOAD = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++; if (f_sum !== 16'hF800) $display("FAIL short_checksum got %h exp f800", f_sum); else n_pass++;
        n_chk++; if ({f_ok, f_short} !== 2'b01) $display("FAIL short_full_size got %b exp 01", {f_ok, f_short}); else n_pass++;
        n_chk++; if ({s_ok, s_short} !== 2'b10) $display("FAIL short_small_size got %b exp 10", {s_ok, s_short}); else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        DL_READY = 1'b0; IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        wr_byte(25'h10, 8'hA1);
        wr_byte(25'h11, 8'hA2);
        n_chk++; if (s_wait !== 1'b1) $display("FAIL rst_mid_full got %b exp 1", s_wait); else n_pass++;
        #1 RESET = 1'b1;
        #1;
        n_chk++; if ({s_valid, s_wait, s_core} !== 3'b001) $display("FAIL rst_mid_async got %b exp 001", {s_valid, s_wait, s_core}); else n_pass++;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        wr_byte(25'h12, 8'hA3);
        n_chk++; if (s_valid !== 1'b0) $display("FAIL rst_mid_idle got %b exp 0", s_valid); else n_pass++;
        IOCTL_DOWNLOAD = 1'b0;
        @(negedge CLK);
        IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
        wr_byte(25'h13, 8'hA4);
        n_chk++; if (s_valid !== 1'b1 || s_data !== 8'hA4) $display("FAIL rst_mid_new_session got %b/%h exp 1/a4", s_valid, s_data); else n_pass++;
        IOCTL_DOWNLOAD = 1'b0; DL_READY = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overrun;
        test_held_wr;
        test_other_index;
        test_short;
        test_reset_mid_load;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_dl_ctrl.md
ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 0: IOCTL_INDEX value that selects the game ROM download.
REQ-002 SHALL have parameter ROM_SIZE, default 'h58300: expected byte count of the ROM set.
REQ-003 SHALL have parameter HOLD_CYCLES, default 256: CLK cycles of core reset after download end (minimum 1).
REQ-004 SHALL have ports, clock and reset first:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- IOCTL_DOWNLOAD  in  1  download session active.
- IOCTL_INDEX  in  8  download target index.
- IOCTL_WR  in  1  byte strobe; may be held high more than one cycle.
- IOCTL_ADDR  in  25  byte address.
- IOCTL_DATA  in  8  byte data.
- IOCTL_WAIT  out  1  backpressure to the HPS.
- DL_ADDR  out  25  buffered write address to the ROM region selector and EPROM ports.
- DL_DATA  out  8  buffered write data.
- DL_VALID  out  1  DL_ADDR and DL_DATA valid.
- DL_READY  in  1  downstream accepts the head entry this cycle.
- CORE_RESET  out  1  holds the game CPUs in reset.
- ROM_OK  out  1  last matching download complete and full length.
- ROM_SHORT  out  1  last matching download ended with fewer than ROM_SIZE bytes.
- OVERRUN  out  1  sticky: a byte was dropped.
- CHECKSUM  out  16  modulo-2^16 sum of the bytes accepted in the last matching download.

Function
REQ-005 SHALL run an FSM with states IDLE, LOAD, DRAIN, HOLD and RUN; reset enters IDLE.
REQ-006 IDLE -> LOAD SHALL occur when IOCTL_DOWNLOAD=1 and IOCTL_INDEX=ROM_INDEX.
- On LOAD entry: clear CHECKSUM, byte count, ROM_OK, ROM_SHORT and OVERRUN.
REQ-007 Bytes SHALL be accepted only in LOAD, and only on the rising edge of IOCTL_WR.
- The edge detector SHALL use the IOCTL_WR value registered on the previous cycle.
- A held-high IOCTL_WR SHALL produce exactly one accept.
REQ-008 Accepted bytes SHALL enter a 2-entry FIFO.
- DL_VALID SHALL rise the cycle after the accept; the accept-to-DL_VALID latency is 1 cycle.
- DL_ADDR and DL_DATA SHALL stay stable while DL_VALID=1 and DL_READY=0.
- The head entry SHALL be popped on the cycle DL_VALID and DL_READY are both 1.
REQ-009 IOCTL_WAIT SHALL equal 1 whenever the FIFO holds 2 entries, and 0 otherwise.
REQ-010 Push and pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-011 An accept while the FIFO is full and no pop occurs SHALL drop the byte and set OVERRUN.
- A dropped byte SHALL NOT affect CHECKSUM or the byte count.
REQ-012 Each accepted byte SHALL add to CHECKSUM (16-bit wrap) and increment a 25-bit byte count (saturating).
REQ-013 LOAD -> DRAIN SHALL occur when IOCTL_DOWNLOAD falls.
- DRAIN -> HOLD SHALL occur on the first cycle the FIFO is empty.
REQ-014 On entry to HOLD:
- ROM_SHORT SHALL equal (byte count < ROM_SIZE).
- ROM_OK SHALL equal (not ROM_SHORT and not OVERRUN).
REQ-015 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to RUN.
- CORE_RESET SHALL be 1 in every state except RUN.
REQ-016 A matching download start in HOLD or RUN SHALL return the FSM to LOAD, applying the REQ-006 clears.
REQ-017 A matching download start in DRAIN SHALL be deferred until HOLD is entered.
REQ-018 Non-matching IOCTL_INDEX sessions, and IOCTL_WR outside LOAD, SHALL be ignored entirely, with no output change.

Reset
REQ-019 RESET=1 SHALL asynchronously force:
- FIFO empty, DL_VALID=0, IOCTL_WAIT=0.
- CORE_RESET=1, ROM_OK=0, ROM_SHORT=0, OVERRUN=0.
- CHECKSUM=0, DL_ADDR=0, DL_DATA=0, state IDLE.
REQ-020 RESET asserted mid-download SHALL discard buffered bytes; after release the FSM waits in IDLE for a new IOCTL_DOWNLOAD rising.

Structure
REQ-021 The state enum, the ROM_INDEX default and the ROM_SIZE default SHALL live in the shared core package beside the ROM region base addresses.
REQ-022 The 2-entry FIFO SHALL be a sub-module dl_fifo2 (parameterised width, async active-high reset); the FSM, counters and checksum stay in rom_dl_ctrl.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Index 0, 16 bytes 0x01..0x10 at addresses 0..15, DL_READY=1, ROM_SIZE=16: DL_VALID one cycle after each accept; CHECKSUM=0x0088; ROM_OK=1; CORE_RESET falls 256 cycles after the FIFO empties.
- DL_READY=0, three IOCTL_WR edges: IOCTL_WAIT=1 after the second; the third is dropped; OVERRUN=1; ROM_OK=0.
- IOCTL_WR held high 5 cycles: exactly one DL_VALID entry.
- Index 1 download of 100 bytes: no DL_VALID; CHECKSUM and flags unchanged.
- ROM_SIZE='h58300, 'h1000 bytes sent: ROM_SHORT=1 and ROM_OK=0.
- RESET pulse mid-LOAD with 2 entries buffered: DL_VALID=0 and CORE_RESET=1 immediately.
